// File: rtl/hamming_encoder_tx.sv
// hamming_encoder_tx
// SECDED (8,4) Hamming encoder feeding a show-ahead codeword FIFO.
// Each accepted nibble is encoded, optionally corrupted by an XOR mask,
// and queued together with a flag recording whether the mask was nonzero.
// Codewords drain through a valid/ready port.
// Saturating counters track delivered words and delivered injected words.

module hamming_encoder_tx #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               data_in,
    input  logic [7:0]               inj_mask,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               code_out,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]         word_count,
    output logic [CNT_W-1:0]         inj_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    // Codeword layout uses position p = index+1.
    // Data sits at p = 3, 5, 6, 7 and parity at p = 1, 2, 4.
    // Bit 7 carries overall parity, so the decoder can tell single errors
    // from double errors.
    function automatic logic [7:0] hamming_encode(input logic [3:0] d);
        logic [7:0] c;
        c    = '0;
        c[6] = d[3];
        c[5] = d[2];
        c[4] = d[1];
        c[2] = d[0];
        c[0] = c[6] ^ c[4] ^ c[2];
        c[1] = c[6] ^ c[5] ^ c[2];
        c[3] = c[6] ^ c[5] ^ c[4];
        c[7] = ^c[6:0];
        return c;
    endfunction

    // Counters stick at all-ones rather than wrapping.
    // A saturated value therefore always means "at least this many".
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // ---- stage p0: combinational encode of the incoming nibble ----
    logic [7:0] code_p0;
    logic       inj_flag_p0;
    logic [8:0] entry_p0;
    logic       push;
    logic       pop;

    assign code_p0     = hamming_encode(data_in);
    assign inj_flag_p0 = |inj_mask;
    assign entry_p0    = {inj_flag_p0, code_p0 ^ inj_mask};

    // in_ready is forced low while rst is high.
    // This stops a handshake from completing during reset.
    assign in_ready  = !rst && (fifo_level < LVL_W'(DEPTH));
    assign out_valid = (fifo_level != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // ---- stage p1: FIFO storage, pointers and occupancy ----
    logic [8:0]       mem_p1 [DEPTH];
    logic [PTR_W-1:0] wr_ptr_p1;
    logic [PTR_W-1:0] rd_ptr_p1;
    logic [8:0]       head_p1;

    // Entry storage.
    // The contents are don't-care after reset, so this array has no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_p1[wr_ptr_p1] <= entry_p0;
        end
    end

    // Write and read pointers.
    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_p1 <= '0;
            rd_ptr_p1 <= '0;
        end else begin
            if (push) begin
                wr_ptr_p1 <= wr_ptr_p1 + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_p1 <= rd_ptr_p1 + PTR_W'(1);
            end
        end
    end

    // Occupancy.
    // A simultaneous push and pop leaves the level unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_level <= '0;
        end else begin
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // ---- stage p2: show-ahead output and delivery statistics ----
    // The head entry is exposed directly.
    // The output is forced to zero when the FIFO is empty, so stale
    // storage never leaks out.
    assign head_p1  = mem_p1[rd_ptr_p1];
    assign code_out = out_valid ? head_p1[7:0] : 8'h00;

    // Statistics counters advance only when a codeword actually leaves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_count <= '0;
            inj_count  <= '0;
        end else if (pop) begin
            word_count <= sat_inc(word_count);
            if (head_p1[8]) begin
                inj_count <= sat_inc(inj_count);
            end
        end
    end

endmodule

// File: tb/tb_hamming_encoder_tx.sv
// tb_hamming_encoder_tx
// Directed bench for the SECDED (8,4) encoder FIFO.
// The main instance uses default parameters.
// A second instance with 2-bit counters exercises saturation.

module tb_hamming_encoder_tx;

    localparam int DEPTH = 4;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       data_in;
    logic [7:0]       inj_mask;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       code_out;
    logic [LVL_W-1:0] fifo_level;
    logic [15:0]      word_count;
    logic [15:0]      inj_count;

    logic             s_in_valid;
    logic             s_in_ready;
    logic [3:0]       s_data_in;
    logic [7:0]       s_inj_mask;
    logic             s_out_valid;
    logic             s_out_ready;
    logic [7:0]       s_code_out;
    logic [LVL_W-1:0] s_fifo_level;
    logic [1:0]       s_word_count;
    logic [1:0]       s_inj_count;

    int n_vec;
    int n_bad;

    hamming_encoder_tx #(.DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .data_in    (data_in),
        .inj_mask   (inj_mask),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .code_out   (code_out),
        .fifo_level (fifo_level),
        .word_count (word_count),
        .inj_count  (inj_count)
    );

    hamming_encoder_tx #(.DEPTH(DEPTH), .CNT_W(2)) dut_sat (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (s_in_valid),
        .in_ready   (s_in_ready),
        .data_in    (s_data_in),
        .inj_mask   (s_inj_mask),
        .out_valid  (s_out_valid),
        .out_ready  (s_out_ready),
        .code_out   (s_code_out),
        .fifo_level (s_fifo_level),
        .word_count (s_word_count),
        .inj_count  (s_inj_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net against a hung run.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [3:0] d;
        logic [7:0] m;
        logic [7:0] code;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Generic Hamming construction.
    // The parity bit at position 2^k covers every position with bit k set.
    function automatic logic [7:0] ref_code(input logic [3:0] d);
        logic [7:0] c;
        logic       p;
        c    = '0;
        c[2] = d[0];
        c[4] = d[1];
        c[5] = d[2];
        c[6] = d[3];
        for (int k = 0; k < 3; k++) begin
            p = 1'b0;
            for (int pos = 1; pos <= 7; pos++) begin
                if (pos[k] && (pos != (1 << k))) p = p ^ c[pos-1];
            end
            c[(1 << k) - 1] = p;
        end
        c[7] = ^c[6:0];
        return c;
    endfunction

    initial begin
        int          acc;
        int          exp_wc;
        int          exp_ic;
        logic [3:0]  cur;

        n_vec = 0;
        n_bad = 0;

        tbl[0] = '{4'h0, 8'h00, 8'h00};
        tbl[1] = '{4'h1, 8'h00, 8'h87};
        tbl[2] = '{4'hB, 8'h00, 8'h55};
        tbl[3] = '{4'hF, 8'h00, 8'hFF};
        tbl[4] = '{4'hB, 8'h04, 8'h51};
        tbl[5] = '{4'hB, 8'h00, 8'h55};
        tbl[6] = '{4'h8, 8'h00, 8'h4B};
        tbl[7] = '{4'h4, 8'h00, 8'hAA};
        tbl[8] = '{4'h0, 8'h80, 8'h80};
        tbl[9] = '{4'h2, 8'h00, 8'h99};

        rst         = 1'b1;
        in_valid    = 1'b0;
        data_in     = '0;
        inj_mask    = '0;
        out_ready   = 1'b0;
        s_in_valid  = 1'b0;
        s_data_in   = '0;
        s_inj_mask  = '0;
        s_out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",   32'(in_ready),   32'd0);
        chk("rst_out_valid",  32'(out_valid),  32'd0);
        chk("rst_code_out",   32'(code_out),   32'h00);
        chk("rst_level",      32'(fifo_level), 32'd0);
        chk("rst_word_count", 32'(word_count), 32'd0);
        chk("rst_inj_count",  32'(inj_count),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Encode and injection table: one word in, one word out
        out_ready = 1'b1;
        exp_wc    = 0;
        exp_ic    = 0;
        for (int i = 0; i < 10; i++) begin
            data_in  = tbl[i].d;
            inj_mask = tbl[i].m;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            chk($sformatf("tbl%0d_valid", i), 32'(out_valid),  32'd1);
            chk($sformatf("tbl%0d_code", i),  32'(code_out),   32'(tbl[i].code));
            chk($sformatf("tbl%0d_level", i), 32'(fifo_level), 32'd1);
            @(posedge clk);
            #1;
            exp_wc++;
            if (tbl[i].m != 8'h00) exp_ic++;
            chk($sformatf("tbl%0d_empty", i), 32'(out_valid),  32'd0);
            chk($sformatf("tbl%0d_wc", i),    32'(word_count), 32'(exp_wc));
            chk($sformatf("tbl%0d_ic", i),    32'(inj_count),  32'(exp_ic));
        end
        inj_mask = 8'h00;

        // Full / backpressure: offer six words with out_ready low
        out_ready = 1'b0;
        acc       = 0;
        for (int i = 1; i <= 6; i++) begin
            data_in  = 4'(i);
            in_valid = 1'b1;
            if (in_ready) acc++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("full_accepted", 32'(acc),        32'(DEPTH));
        chk("full_in_ready", 32'(in_ready),   32'd0);
        chk("full_level",    32'(fifo_level), 32'(DEPTH));
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("drain%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("drain%0d_code", i),  32'(code_out),  32'(ref_code(4'(i + 1))));
            @(posedge clk);
            #1;
            if (i == 0) chk("drain_in_ready_back", 32'(in_ready), 32'd1);
        end
        exp_wc += DEPTH;
        chk("drain_empty", 32'(out_valid),  32'd0);
        chk("drain_level", 32'(fifo_level), 32'd0);
        chk("drain_wc",    32'(word_count), 32'(exp_wc));

        // Wrap and concurrency: 3*DEPTH words streamed back to back
        for (int i = 0; i < 3 * DEPTH; i++) begin
            cur      = 4'((i + 5) % 16);
            data_in  = cur;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            chk($sformatf("strm%0d_level", i), 32'(fifo_level), 32'd1);
            chk($sformatf("strm%0d_code", i),  32'(code_out),   32'(ref_code(cur)));
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        exp_wc += 3 * DEPTH;
        chk("strm_level_end", 32'(fifo_level), 32'd0);
        chk("strm_wc",        32'(word_count), 32'(exp_wc));

        // Reset mid-stream with three words queued
        out_ready = 1'b0;
        for (int i = 7; i <= 9; i++) begin
            data_in  = 4'(i);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("pre_rst_level", 32'(fifo_level), 32'd3);
        rst = 1'b1;
        #2;
        chk("mid_rst_valid",    32'(out_valid),  32'd0);
        chk("mid_rst_code",     32'(code_out),   32'h00);
        chk("mid_rst_level",    32'(fifo_level), 32'd0);
        chk("mid_rst_wc",       32'(word_count), 32'd0);
        chk("mid_rst_ic",       32'(inj_count),  32'd0);
        chk("mid_rst_in_ready", 32'(in_ready),   32'd0);
        #2;
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        data_in   = 4'hF;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("post_rst_valid", 32'(out_valid),  32'd1);
        chk("post_rst_code",  32'(code_out),   32'hFF);
        chk("post_rst_level", 32'(fifo_level), 32'd1);
        @(posedge clk);
        #1;
        chk("post_rst_wc", 32'(word_count), 32'd1);

        // Saturation on the 2-bit counter instance
        s_out_ready = 1'b1;
        s_inj_mask  = 8'h01;
        for (int i = 0; i < 5; i++) begin
            s_data_in  = 4'(i);
            s_in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        s_in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("sat_level", 32'(s_fifo_level), 32'd0);
        chk("sat_wc",    32'(s_word_count), 32'd3);
        chk("sat_ic",    32'(s_inj_count),  32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/hamming_encoder_tx.md
# hamming_encoder_tx

Transmit-side SECDED (8,4) Hamming encoder that sits directly upstream of the Hamming decoder. It accepts 4-bit data nibbles over a valid/ready handshake and encodes each into an 8-bit codeword using exactly the bit layout the decoder checks. An optional per-word error-injection mask can corrupt codewords deliberately. Codewords are buffered in a small FIFO and presented downstream with valid/ready, alongside saturating statistics counters.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥ 2
- CNT_W, 16, width of statistics counters
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream nibble valid
- in_ready  output  1  block can accept a nibble
- data_in  input  4  data nibble d[3:0]
- inj_mask  input  8  XOR mask applied to this word's codeword, sampled with data_in
- out_valid  output  1  codeword available
- out_ready  input  1  downstream accepts codeword
- code_out  output  8  codeword c[7:0]
- fifo_level  output  $clog2(DEPTH)+1  entries currently held
- word_count  output  CNT_W  codewords delivered, saturating
- inj_count  output  CNT_W  delivered codewords whose inj_mask was nonzero, saturating

## Operation
- Encoding is combinational on data_in and follows position p = index+1:
  - Data bits: c6=d3, c5=d2, c4=d1, c2=d0.
  - Parity bits: c0=c6^c4^c2, c1=c6^c5^c2, c3=c6^c5^c4.
  - Overall parity: c7 = XOR of c6..c0.
- Stored entry is {inj_flag, code ^ inj_mask}, where inj_flag = |inj_mask.
- Push: occurs when in_valid && in_ready. in_ready = !rst && (fifo_level < DEPTH).
- Pop: occurs when out_valid && out_ready. out_valid = (fifo_level != 0).
- Output is show-ahead: code_out is the head entry while out_valid=1, and 8'h00 otherwise.
- Simultaneous push and pop:
  - Level is unchanged and both pointers advance.
  - This is legal at any nonzero level below DEPTH.
  - At level DEPTH, in_ready=0, so no push occurs. Full pass-through is not supported.
  - At level 0, the pop is impossible and only the push occurs. There is no combinational bypass.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Counters update on pop:
  - word_count increments by 1 on every pop.
  - inj_count increments by 1 when the popped entry's inj_flag=1.
  - Both counters hold at 2^CNT_W−1 (saturate).
- Reset values:
  - Pointers 0, fifo_level 0, out_valid 0, code_out 8'h00, in_ready 0, word_count 0, inj_count 0.
  - Stored data is don't-care.
- A reset asserted mid-operation discards all entries immediately (asynchronous). No partial handshake completes in that cycle.

## Timing
- Latency: a nibble pushed at edge N is visible as out_valid=1 / code_out after edge N (same cycle it lands); minimum 1 cycle from in_valid to out_valid.
- Throughput: 1 word/cycle when out_ready is held high.
- in_ready deasserts the cycle after the edge at which fifo_level reaches DEPTH. It reasserts the cycle after the first pop.
- in_ready goes high in the first cycle after rst deasserts.
- fifo_level, word_count and inj_count are registered and reflect handshakes completed at the previous edge.
- Downstream must hold out_ready independently of code_out. Upstream must hold data_in and inj_mask stable while in_valid=1 and in_ready=0.

## Test plan
- Encode table: push d=0x0, 0x1, 0xB, 0xF with mask 0 and out_ready=1. Required code_out sequence: 0x00, 0x87, 0x55, 0xFF. Required final word_count=4, inj_count=0.
- Injection: push d=0xB with inj_mask=0x04, then d=0xB with mask 0x00. Required code_out 0x51, then 0x55. Required inj_count=1, word_count=2.
- Full/backpressure: hold out_ready=0 and push DEPTH+2 words 0x1..0x6.
  - After DEPTH accepts: in_ready=0, fifo_level=DEPTH.
  - Releasing out_ready: exactly the first DEPTH words are delivered, in order.
- Wrap and concurrency: with out_ready=1 and in_valid=1, stream 3×DEPTH words. Required: level stays at 1, order is preserved across pointer wrap, and no word is lost or duplicated.
- Saturation (CNT_W=2): deliver 5 words with nonzero masks. Required word_count=3 and inj_count=3.
- Reset mid-stream: with 3 words queued, pulse rst for half a cycle.
  - Required immediately: out_valid=0, code_out=0x00, fifo_level=0, counters=0.
  - Required after release: in_ready=1, and the next push appears normally.
